// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, two-entry skid buffer,
// synchronous flush with NOP injection and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(16'h1000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [15:0]      stall_cycles
);

  localparam int unsigned STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = 16'hFFFF;

  // Occupancy doubles as the state encoding.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             in_fire;
  logic             out_fire;

  // Handshake qualifiers use only registered ready/valid, so no comb path
  // from out_ready to in_ready.
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;

  // The main entry is kept at NOP_VALUE whenever it is invalid, so out_data
  // is a plain register output.
  assign out_data  = main_data;
  assign occupancy = 2'(state);

  // Stall counter: counts cycles a valid payload waits on downstream.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != STALL_MAX)) begin
      stall_cycles <= stall_cycles + STALL_W'(1);
    end
  end

  // Stage state machine: main/skid storage, valid and in_ready registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_data <= NOP_VALUE;
      skid_data <= NOP_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      // Held payloads and any payload offered this cycle are dropped.
      state     <= EMPTY;
      main_data <= NOP_VALUE;
      skid_data <= NOP_VALUE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_data <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
            in_ready  <= 1'b1;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data <= in_data;
          end else if (in_fire) begin
            skid_data <= in_data;
            state     <= FULL;
            in_ready  <= 1'b0;
          end else if (out_fire) begin
            main_data <= NOP_VALUE;
            out_valid <= 1'b0;
            state     <= EMPTY;
            in_ready  <= 1'b1;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_data <= skid_data;
            skid_data <= NOP_VALUE;
            state     <= ONE;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          main_data <= NOP_VALUE;
          skid_data <= NOP_VALUE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_pipe_stage_reg;

  localparam logic [15:0] NOP = 16'h1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [15:0] in_data, out_data, stall_cycles;
  logic [1:0]  occupancy;

  logic        rst2, in_valid2, in_ready2, out_valid2, out_ready2, flush2;
  logic [39:0] in_data2, out_data2;
  logic [1:0]  occupancy2;
  logic [15:0] stall_cycles2;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  // Model state: held payloads in FIFO order, registered ready, stall count.
  logic [15:0] q[$];
  logic        m_rdy   = 1'b1;
  logic [15:0] m_stall = '0;

  always #5 clk = ~clk;

  pipe_stage_reg dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .flush(flush), .occupancy(occupancy),
    .stall_cycles(stall_cycles)
  );

  pipe_stage_reg #(.WIDTH(40), .NOP_VALUE(40'h0)) dut40 (
    .clk(clk), .rst(rst2), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_data(out_data2), .flush(flush2), .occupancy(occupancy2),
    .stall_cycles(stall_cycles2)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: a stage holds up to two payloads, strict FIFO.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_rdy   <= 1'b1;
      m_stall <= '0;
    end else begin
      automatic bit inf  = in_valid && m_rdy;
      automatic bit outf = (q.size() > 0) && out_ready;
      if ((q.size() > 0) && !out_ready && (m_stall != 16'hFFFF))
        m_stall <= m_stall + 16'd1;
      if (flush) begin
        q.delete();
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(in_data);
      end
      m_rdy <= (q.size() < 2);
    end
  end

  // Compare process: DUT outputs against the model every cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("m_out_data", 64'(out_data), 64'((q.size() > 0) ? q[0] : NOP));
      chk("m_occupancy", 64'(occupancy), 64'(q.size()));
      chk("m_in_ready", 64'(in_ready), 64'(m_rdy));
      chk("m_stall", 64'(stall_cycles), 64'(m_stall));
    end
  end

  // Drive one cycle of inputs, then land 1 time unit after the edge.
  task automatic step(input logic iv, input logic [15:0] id, input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b0; in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
    rst2 = 1'b0; in_valid2 = 0; in_data2 = '0; out_ready2 = 0; flush2 = 0;
    #1;
    chk_en = 1'b1;

    // Reset held with random inputs.
    for (int i = 0; i < 5; i++)
      step(1'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'h1000);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_stall", 64'(stall_cycles), 64'd0);
    in_valid = 0; flush = 0;
    #2 rst = 1'b1;

    // Streaming 1..8 with out_ready high: one cycle latency, occupancy <= 1.
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 16'(i), 1'b1, 1'b0);
      chk("stream_data", 64'(out_data), 64'(i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("stream_drain", 64'(out_valid), 64'd0);

    // Backpressure: out_ready low from cycle 3 for 5 cycles.
    do_reset();
    d = 16'hA000;
    for (int c = 1; c <= 7; c++) begin
      automatic logic acc = in_ready;
      step(1'b1, d, (c < 3), 1'b0);
      if (acc) d = d + 16'd1;
    end
    chk("bp_stall", 64'(stall_cycles), 64'd5);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_occ", 64'(occupancy), 64'd2);
    chk("bp_head", 64'(out_data), 64'hA001);
    chk("bp_next_in", 64'(d), 64'hA003);
    for (int c = 0; c < 6; c++) begin
      automatic logic acc = in_ready;
      step(1'b1, d, 1'b1, 1'b0);
      if (acc) d = d + 16'd1;
    end
    for (int c = 0; c < 4; c++) step(1'b0, 16'h0, 1'b1, 1'b0);
    chk("bp_drained", 64'(occupancy), 64'd0);

    // Flush while FULL drops held and offered payloads.
    do_reset();
    step(1'b1, 16'h0011, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 1'b0, 1'b0);
    chk("fl_full", 64'(occupancy), 64'd2);
    step(1'b1, 16'h0033, 1'b0, 1'b1);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_data", 64'(out_data), 64'h1000);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_ready", 64'(in_ready), 64'd1);
    for (int c = 0; c < 3; c++) begin
      step(1'b0, 16'h0, 1'b1, 1'b0);
      chk("fl_no_33", 64'(out_valid), 64'd0);
    end
    // Flush coinciding with out_ready rise still ends EMPTY.
    step(1'b1, 16'h0044, 1'b0, 1'b0);
    step(1'b1, 16'h0055, 1'b1, 1'b1);
    chk("fl_rise_occ", 64'(occupancy), 64'd0);
    chk("fl_rise_data", 64'(out_data), 64'h1000);

    // Stall counter saturation.
    do_reset();
    step(1'b1, 16'h0077, 1'b0, 1'b0);
    for (int c = 0; c < 65540; c++) step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("sat_stall", 64'(stall_cycles), 64'hFFFF);
    for (int c = 0; c < 5; c++) step(1'b0, 16'h0, 1'b0, 1'b1);
    chk("sat_hold", 64'(stall_cycles), 64'hFFFF);

    // 40-bit instance: asynchronous reset while FULL.
    step(1'b0, 16'h0, 1'b0, 1'b0);
    rst2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = 40'hAA_0000_0001;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    in_data2 = 40'hAA_0000_0002;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    in_valid2 = 1'b0;
    chk("w40_full", 64'(occupancy2), 64'd2);
    chk("w40_head", 64'(out_data2), 64'hAA_0000_0001);
    #2 rst2 = 1'b0;
    #1;
    chk("w40_rst_valid", 64'(out_valid2), 64'd0);
    chk("w40_rst_data", 64'(out_data2), 64'd0);
    chk("w40_rst_occ", 64'(occupancy2), 64'd0);
    chk("w40_rst_ready", 64'(in_ready2), 64'd1);
    #1 rst2 = 1'b1;
    in_valid2 = 1'b1; in_data2 = 40'h12_3456_789A; out_ready2 = 1'b1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    in_valid2 = 1'b0;
    chk("w40_first_valid", 64'(out_valid2), 64'd1);
    chk("w40_first_data", 64'(out_data2), 64'h12_3456_789A);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
